// File: rtl/pipe_pkg.sv
// Shared pipeline-stage constants and the entry record carried between stages.
// The MIPS reset and exception-handler addresses are defined here.
package pipe_pkg;

   localparam int unsigned PAYLOAD_W = 160;
   localparam int unsigned PC_W      = 32;
   localparam int unsigned EXC_W     = 5;

   localparam logic [PC_W-1:0]  RESET_PC   = 32'h0000_3000;
   localparam logic [PC_W-1:0]  HANDLER_PC = 32'h0000_4180;
   localparam logic [EXC_W-1:0] EXC_NONE   = '0;

   typedef struct packed {
      logic [PC_W-1:0]      pc;
      logic [EXC_W-1:0]     exc;
      logic                 bd;
      logic [PAYLOAD_W-1:0] payload;
   } stage_entry_t;

endpackage

// File: rtl/pipe_stage_buf_if.sv
// Upstream/downstream valid-ready bundle of one pipeline stage.
// The slave modport is the stage; the master modport is its environment.
interface pipe_stage_buf_if #(
   parameter int unsigned PAYLOAD_W = pipe_pkg::PAYLOAD_W,
   parameter int unsigned PC_W      = pipe_pkg::PC_W,
   parameter int unsigned EXC_W     = pipe_pkg::EXC_W
);
   logic                 in_valid;
   logic                 in_ready;
   logic [PC_W-1:0]      in_pc;
   logic [EXC_W-1:0]     in_exc;
   logic                 in_bd;
   logic [PAYLOAD_W-1:0] in_payload;

   logic                 out_valid;
   logic                 out_ready;
   logic [PC_W-1:0]      out_pc;
   logic [EXC_W-1:0]     out_exc;
   logic                 out_bd;
   logic [PAYLOAD_W-1:0] out_payload;

   modport master (
      output in_valid, in_pc, in_exc, in_bd, in_payload, out_ready,
      input  in_ready, out_valid, out_pc, out_exc, out_bd, out_payload
   );

   modport slave (
      input  in_valid, in_pc, in_exc, in_bd, in_payload, out_ready,
      output in_ready, out_valid, out_pc, out_exc, out_bd, out_payload
   );

endinterface

// File: rtl/pipe_entry_reg.sv
// One pipeline entry register: clear-to-PC, squashing load, bubble and drop.
// Priority is clear > load > bubble > drop; otherwise the entry holds.
module pipe_entry_reg #(
   parameter int unsigned PAYLOAD_W = pipe_pkg::PAYLOAD_W,
   parameter int unsigned PC_W      = pipe_pkg::PC_W,
   parameter int unsigned EXC_W     = pipe_pkg::EXC_W
) (
   input  logic                 clk,
   input  logic                 clear,
   input  logic [PC_W-1:0]      clear_pc,
   input  logic                 load,
   input  logic                 bubble,
   input  logic                 drop,
   input  logic [PC_W-1:0]      d_pc,
   input  logic [EXC_W-1:0]     d_exc,
   input  logic                 d_bd,
   input  logic [PAYLOAD_W-1:0] d_payload,
   output logic                 q_valid,
   output logic [PC_W-1:0]      q_pc,
   output logic [EXC_W-1:0]     q_exc,
   output logic                 q_bd,
   output logic [PAYLOAD_W-1:0] q_payload
);
   import pipe_pkg::*;

   always_ff @(posedge clk) begin
      if (clear) begin
         q_valid   <= 1'b0;
         q_pc      <= clear_pc;
         q_exc     <= '0;
         q_bd      <= 1'b0;
         q_payload <= '0;
      end else if (load) begin
         q_valid   <= 1'b1;
         q_pc      <= d_pc;
         q_exc     <= d_exc;
         q_bd      <= d_bd;
         // a faulting entry keeps pc/exc/bd for the handler but no operands
         q_payload <= (d_exc != EXC_W'(EXC_NONE)) ? '0 : d_payload;
      end else if (bubble) begin
         q_valid   <= 1'b0;
         q_pc      <= d_pc;
         q_exc     <= '0;
         q_bd      <= d_bd;
         q_payload <= '0;
      end else if (drop) begin
         q_valid   <= 1'b0;
      end
   end

endmodule

// File: rtl/pipe_stage_buf.sv
// Elastic pipeline-stage register with optional two-entry skid buffer.
// Reset and flush clear both entries and park out_pc at a fixed address.
module pipe_stage_buf #(
   parameter int unsigned     PAYLOAD_W  = pipe_pkg::PAYLOAD_W,
   parameter int unsigned     PC_W       = pipe_pkg::PC_W,
   parameter int unsigned     EXC_W      = pipe_pkg::EXC_W,
   parameter logic [PC_W-1:0] RESET_PC   = PC_W'(pipe_pkg::RESET_PC),
   parameter logic [PC_W-1:0] HANDLER_PC = PC_W'(pipe_pkg::HANDLER_PC),
   parameter bit              SKID       = 1'b1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   flush,
   pipe_stage_buf_if.slave        bus,
   output logic [1:0]             occupancy
);
   logic                 ctrl;
   logic [PC_W-1:0]      clear_pc;
   logic                 main_free;
   logic                 in_fire;
   logic                 main_load;
   logic                 main_bubble;

   logic                 skid_valid;
   logic [PC_W-1:0]      skid_pc;
   logic [EXC_W-1:0]     skid_exc;
   logic                 skid_bd;
   logic [PAYLOAD_W-1:0] skid_payload;

   logic [PC_W-1:0]      src_pc;
   logic [EXC_W-1:0]     src_exc;
   logic                 src_bd;
   logic [PAYLOAD_W-1:0] src_payload;

   assign ctrl      = reset | flush;
   assign clear_pc  = reset ? RESET_PC : HANDLER_PC;
   assign main_free = !bus.out_valid | bus.out_ready;
   assign in_fire   = bus.in_valid & bus.in_ready;

   // the skid entry is always older than the input, so it goes first
   always_comb begin
      src_pc      = bus.in_pc;
      src_exc     = bus.in_exc;
      src_bd      = bus.in_bd;
      src_payload = bus.in_payload;
      if (skid_valid) begin
         src_pc      = skid_pc;
         src_exc     = skid_exc;
         src_bd      = skid_bd;
         src_payload = skid_payload;
      end
   end

   assign main_load   = main_free & (skid_valid | in_fire);
   assign main_bubble = main_free & !skid_valid & !in_fire;

   pipe_entry_reg #(.PAYLOAD_W(PAYLOAD_W), .PC_W(PC_W), .EXC_W(EXC_W)) u_main (
      .clk       (clk),
      .clear     (ctrl),
      .clear_pc  (clear_pc),
      .load      (main_load),
      .bubble    (main_bubble),
      .drop      (1'b0),
      .d_pc      (src_pc),
      .d_exc     (src_exc),
      .d_bd      (src_bd),
      .d_payload (src_payload),
      .q_valid   (bus.out_valid),
      .q_pc      (bus.out_pc),
      .q_exc     (bus.out_exc),
      .q_bd      (bus.out_bd),
      .q_payload (bus.out_payload)
   );

   generate
      if (SKID) begin : g_skid
         assign bus.in_ready = !skid_valid & !ctrl;

         pipe_entry_reg #(.PAYLOAD_W(PAYLOAD_W), .PC_W(PC_W), .EXC_W(EXC_W)) u_skid (
            .clk       (clk),
            .clear     (ctrl),
            .clear_pc  (clear_pc),
            .load      (!main_free & in_fire),
            .bubble    (1'b0),
            .drop      (main_free & skid_valid),
            .d_pc      (bus.in_pc),
            .d_exc     (bus.in_exc),
            .d_bd      (bus.in_bd),
            .d_payload (bus.in_payload),
            .q_valid   (skid_valid),
            .q_pc      (skid_pc),
            .q_exc     (skid_exc),
            .q_bd      (skid_bd),
            .q_payload (skid_payload)
         );
      end else begin : g_no_skid
         assign bus.in_ready = main_free & !ctrl;
         assign skid_valid   = 1'b0;
         assign skid_pc      = '0;
         assign skid_exc     = '0;
         assign skid_bd      = 1'b0;
         assign skid_payload = '0;
      end
   endgenerate

   assign occupancy = {1'b0, bus.out_valid} + {1'b0, skid_valid};

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Drives a SKID=1 and a SKID=0 stage side by side against a queue-based
// reference of the stage's entry contents.
module tb_pipe_stage_buf;
   import pipe_pkg::*;

   localparam int unsigned PW = pipe_pkg::PAYLOAD_W;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       flush = 1'b0;
   logic [1:0] occ1, occ0;

   always #5 clk = ~clk;

   pipe_stage_buf_if #(.PAYLOAD_W(PW), .PC_W(PC_W), .EXC_W(EXC_W)) bus1 ();
   pipe_stage_buf_if #(.PAYLOAD_W(PW), .PC_W(PC_W), .EXC_W(EXC_W)) bus0 ();

   pipe_stage_buf #(.PAYLOAD_W(PW), .PC_W(PC_W), .EXC_W(EXC_W),
                    .RESET_PC(RESET_PC), .HANDLER_PC(HANDLER_PC), .SKID(1'b1)) dut1 (
      .clk(clk), .reset(reset), .flush(flush), .bus(bus1), .occupancy(occ1));

   pipe_stage_buf #(.PAYLOAD_W(PW), .PC_W(PC_W), .EXC_W(EXC_W),
                    .RESET_PC(RESET_PC), .HANDLER_PC(HANDLER_PC), .SKID(1'b0)) dut0 (
      .clk(clk), .reset(reset), .flush(flush), .bus(bus0), .occupancy(occ0));

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   // reference: held entries in arrival order, plus what out_* shows when empty
   stage_entry_t mq [2][$];
   stage_entry_t idle [2];
   int unsigned  seq [2];
   stage_entry_t drv [2];
   logic         dv [2];
   logic         dr [2];

   task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // exc_mode: 0 none, 1 random, 2 code 12 with all-ones payload
   task automatic cycle(input bit rst, input bit fl, input int unsigned vpct,
                        input int unsigned rpct, input int unsigned exc_mode, input bit bub);
      logic         rdy [2];
      stage_entry_t e;
      logic         obs_v, obs_r;
      stage_entry_t obs;
      logic [1:0]   obs_o;
      bit           main_free;

      @(negedge clk);
      reset = rst;
      flush = fl;
      for (int d = 0; d < 2; d++) begin
         dv[d] = ($urandom_range(99) < vpct);
         dr[d] = ($urandom_range(99) < rpct);
         e.pc  = bub ? PC_W'(32'h3040) : PC_W'(32'h3000 + 4 * seq[d]);
         e.bd  = bub ? 1'b1 : 1'($urandom_range(1));
         if (exc_mode == 2)
            e.exc = EXC_W'(12);
         else if (exc_mode == 1 && $urandom_range(5) == 0)
            e.exc = EXC_W'($urandom_range(31));
         else
            e.exc = EXC_NONE;
         e.payload = (exc_mode == 2) ? '1
                   : {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
         drv[d] = e;
      end
      bus1.in_valid = dv[1]; bus1.out_ready = dr[1];
      bus1.in_pc = drv[1].pc; bus1.in_exc = drv[1].exc;
      bus1.in_bd = drv[1].bd; bus1.in_payload = drv[1].payload;
      bus0.in_valid = dv[0]; bus0.out_ready = dr[0];
      bus0.in_pc = drv[0].pc; bus0.in_exc = drv[0].exc;
      bus0.in_bd = drv[0].bd; bus0.in_payload = drv[0].payload;
      #1;
      for (int d = 0; d < 2; d++) begin
         if (rst || fl)
            rdy[d] = 1'b0;
         else if (d == 1)
            rdy[d] = (mq[d].size() < 2);
         else
            rdy[d] = (mq[d].size() == 0) || dr[d];
         obs_r = (d == 1) ? bus1.in_ready : bus0.in_ready;
         check($sformatf("s%0d_in_ready", d), 192'(obs_r), 192'(rdy[d]));
      end
      for (int d = 0; d < 2; d++) begin
         if (rst || fl) begin
            mq[d].delete();
            idle[d] = '0;
            idle[d].pc = rst ? RESET_PC : HANDLER_PC;
         end else begin
            main_free = (mq[d].size() == 0) || dr[d];
            if (mq[d].size() > 0 && dr[d])
               void'(mq[d].pop_front());
            if (dv[d] && rdy[d]) begin
               e = drv[d];
               if (e.exc != EXC_NONE) e.payload = '0;
               mq[d].push_back(e);
               seq[d]++;
            end
            if (main_free && mq[d].size() == 0) begin
               idle[d] = '0;
               idle[d].pc = drv[d].pc;
               idle[d].bd = drv[d].bd;
            end
         end
      end
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         e = (mq[d].size() > 0) ? mq[d][0] : idle[d];
         if (d == 1) begin
            obs_v = bus1.out_valid; obs_o = occ1;
            obs.pc = bus1.out_pc; obs.exc = bus1.out_exc;
            obs.bd = bus1.out_bd; obs.payload = bus1.out_payload;
         end else begin
            obs_v = bus0.out_valid; obs_o = occ0;
            obs.pc = bus0.out_pc; obs.exc = bus0.out_exc;
            obs.bd = bus0.out_bd; obs.payload = bus0.out_payload;
         end
         check($sformatf("s%0d_out_valid", d), 192'(obs_v), 192'(mq[d].size() > 0));
         check($sformatf("s%0d_occupancy", d), 192'(obs_o), 192'(mq[d].size()));
         check($sformatf("s%0d_out_pc", d), 192'(obs.pc), 192'(e.pc));
         check($sformatf("s%0d_out_exc", d), 192'(obs.exc), 192'(e.exc));
         check($sformatf("s%0d_out_bd", d), 192'(obs.bd), 192'(e.bd));
         check($sformatf("s%0d_out_payload", d), 192'(obs.payload), 192'(e.payload));
      end
   endtask

   initial begin
      seq[0] = 0; seq[1] = 0;
      cycle(1, 0, 0, 100, 0, 0);
      cycle(1, 0, 0, 100, 0, 0);
      check("rst_pc", 192'(bus1.out_pc), 192'(32'h3000));
      check("rst_occ", 192'(occ1), 192'(0));
      seq[0] = 0; seq[1] = 0;

      for (int i = 0; i < 8; i++) cycle(0, 0, 100, 100, 0, 0);
      check("stream_last_pc", 192'(bus1.out_pc), 192'(32'h301C));

      cycle(0, 0, 100, 0, 0, 0);
      check("stall_occ2", 192'(occ1), 192'(2));
      check("stall_ready_low", 192'(bus1.in_ready), 192'(0));
      cycle(0, 0, 100, 0, 0, 0);
      cycle(0, 0, 100, 0, 0, 0);
      for (int i = 0; i < 4; i++) cycle(0, 0, 0, 100, 0, 0);
      check("drain_occ", 192'(occ1), 192'(0));

      cycle(0, 0, 100, 100, 2, 0);
      check("exc_code", 192'(bus1.out_exc), 192'(12));
      check("exc_payload", 192'(bus1.out_payload), 192'(0));

      cycle(0, 0, 100, 0, 0, 0);
      check("pre_flush_occ", 192'(occ1), 192'(2));
      cycle(0, 1, 100, 0, 0, 0);
      check("flush_valid", 192'(bus1.out_valid), 192'(0));
      check("flush_occ", 192'(occ1), 192'(0));
      check("flush_pc", 192'(bus1.out_pc), 192'(32'h4180));
      check("flush_bd", 192'(bus1.out_bd), 192'(0));

      cycle(0, 0, 0, 100, 0, 1);
      check("bubble_pc", 192'(bus1.out_pc), 192'(32'h3040));
      check("bubble_bd", 192'(bus1.out_bd), 192'(1));

      cycle(1, 1, 100, 100, 0, 0);
      check("rst_flush_pc", 192'(bus1.out_pc), 192'(32'h3000));

      for (int i = 0; i < 400; i++)
         cycle(($urandom_range(99) == 0), ($urandom_range(49) == 0), 70, 60, 1, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
